pwm_bank: RTL and testbench

- Multi-channel PWM generator for LED panel row/column dimming. Successor to the single-counter PWM.
- Adds a programmable period, per-channel windows with wrap-around, double-buffered (shadow) configuration that commits only at period boundaries, per-channel polarity, a global enable, and a period-start strobe.
- Sits between the panel configuration registers and the LED driver enable pins.

---
 rtl/pwm_bank.sv | 121 ++++++++++++
 tb/tb_pwm_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: programmable period, per-channel wrap-capable windows,
// shadow configuration committed at period boundaries, per-channel polarity.
module pwm_bank #(
   parameter int                  CTR_LEN     = 8,
   parameter int                  NUM_CH      = 4,
   parameter int                  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter logic [CTR_LEN-1:0]  DEFAULT_TOP = {CTR_LEN{1'b1}},
   parameter logic [NUM_CH-1:0]   INVERT      = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [CTR_LEN-1:0]  wr_lo,
   input  logic [CTR_LEN-1:0]  wr_hi,
   input  logic                top_wr,
   input  logic [CTR_LEN-1:0]  top_val,
   output logic [NUM_CH-1:0]   pwm,
   output logic                period_start
);

   logic [CTR_LEN-1:0] ctr_q, ctr_d;
   logic [CTR_LEN-1:0] top_q, top_d;
   logic [CTR_LEN-1:0] top_sh_q, top_sh_d;

   logic [NUM_CH-1:0][CTR_LEN-1:0] lo_q, lo_d;
   logic [NUM_CH-1:0][CTR_LEN-1:0] hi_q, hi_d;
   logic [NUM_CH-1:0][CTR_LEN-1:0] lo_sh_q, lo_sh_d;
   logic [NUM_CH-1:0][CTR_LEN-1:0] hi_sh_q, hi_sh_d;

   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic [NUM_CH-1:0] win_on;
   logic              ps_q, ps_d;
   logic              boundary;

   // Window decode: lo==hi is empty, lo>hi wraps across the period boundary.
   always_comb begin
      win_on = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (lo_q[i] < hi_q[i]) begin
            win_on[i] = (ctr_q >= lo_q[i]) && (ctr_q < hi_q[i]);
         end else if (lo_q[i] > hi_q[i]) begin
            win_on[i] = (ctr_q >= lo_q[i]) || (ctr_q < hi_q[i]);
         end
      end
   end

   assign boundary = (ctr_q == top_q);

   always_comb begin
      lo_sh_d  = lo_sh_q;
      hi_sh_d  = hi_sh_q;
      top_sh_d = top_sh_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      top_d    = top_q;
      ctr_d    = ctr_q;
      pwm_d    = pwm_q;
      ps_d     = ps_q;

      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en && (wr_ch == CH_W'(i))) begin
            lo_sh_d[i] = wr_lo;
            hi_sh_d[i] = wr_hi;
         end
      end
      if (top_wr) begin
         top_sh_d = top_val;
      end

      // Commits read the registered shadow, so a same-cycle write lands one period later.
      if (!en) begin
         ctr_d = '0;
         pwm_d = '0;
         ps_d  = 1'b0;
         lo_d  = lo_sh_q;
         hi_d  = hi_sh_q;
         top_d = top_sh_q;
      end else begin
         pwm_d = win_on;
         ps_d  = (ctr_q == '0);
         if (boundary) begin
            ctr_d = '0;
            lo_d  = lo_sh_q;
            hi_d  = hi_sh_q;
            top_d = top_sh_q;
         end else begin
            ctr_d = ctr_q + CTR_LEN'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q    <= '0;
         top_q    <= DEFAULT_TOP;
         top_sh_q <= DEFAULT_TOP;
         lo_q     <= '0;
         hi_q     <= '0;
         lo_sh_q  <= '0;
         hi_sh_q  <= '0;
         pwm_q    <= '0;
         ps_q     <= 1'b0;
      end else begin
         ctr_q    <= ctr_d;
         top_q    <= top_d;
         top_sh_q <= top_sh_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         lo_sh_q  <= lo_sh_d;
         hi_sh_q  <= hi_sh_d;
         pwm_q    <= pwm_d;
         ps_q     <= ps_d;
      end
   end

   assign pwm          = pwm_q ^ INVERT;
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: expected pwm per counter value are hand-computed
// nibble tables (ctr 0 in the leftmost hex digit), INVERT = 4'b0010.
module tb_pwm_bank;

   localparam int         CTR_LEN = 8;
   localparam int         NUM_CH  = 4;
   localparam int         CH_W    = 2;
   localparam logic [3:0] INV     = 4'b0010;

   // ch0 2/5, ch1 0/10, ch2 8/2, ch3 4/4, top 9
   localparam logic [39:0] TBL_BASE = 40'h4411100044;
   // ch0 changed to 0/1
   localparam logic [39:0] TBL_P1   = 40'h5400000044;
   // ch0 changed to 0/9
   localparam logic [39:0] TBL_P2   = 40'h5511111154;
   // same windows with top 3, ctr 0..3 only
   localparam logic [39:0] TBL_T3   = 40'h5511000000;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                wr_en;
   logic [CH_W-1:0]     wr_ch;
   logic [CTR_LEN-1:0]  wr_lo;
   logic [CTR_LEN-1:0]  wr_hi;
   logic                top_wr;
   logic [CTR_LEN-1:0]  top_val;
   logic [NUM_CH-1:0]   pwm;
   logic                period_start;

   int n_total = 0;
   int n_bad   = 0;
   logic [4:0] exp_q[$];

   pwm_bank #(
      .CTR_LEN (CTR_LEN),
      .NUM_CH  (NUM_CH),
      .INVERT  (INV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .wr_en        (wr_en),
      .wr_ch        (wr_ch),
      .wr_lo        (wr_lo),
      .wr_hi        (wr_hi),
      .top_wr       (top_wr),
      .top_val      (top_val),
      .pwm          (pwm),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_win(input logic [1:0] ch, input logic [7:0] lo, input logic [7:0] hi);
      wr_en = 1'b1;
      wr_ch = ch;
      wr_lo = lo;
      wr_hi = hi;
   endtask

   // One tick per counter value k; checks outputs for ctr=k against the table.
   task automatic run_ctr(input string tag, input logic [39:0] tbl, input int from, input int to);
      for (int k = from; k <= to; k++) begin
         logic [3:0] nib;
         logic [4:0] e;
         nib = tbl[(9-k)*4 +: 4];
         exp_q.push_back({(k == 0), nib});
         tick;
         e = exp_q.pop_front();
         check_val($sformatf("%s pwm ctr=%0d", tag, k), 32'(pwm), 32'(e[3:0]));
         check_val($sformatf("%s ps ctr=%0d", tag, k), 32'(period_start), 32'(e[4]));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_lo = '0; wr_hi = '0;
      top_wr = 1'b0; top_val = '0;

      // Reset / idle
      repeat (3) tick;
      check_val("rst pwm", 32'(pwm), 32'(INV));
      check_val("rst ps", 32'(period_start), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      tick;
      check_val("en0 pwm", 32'(pwm), 32'(INV));
      check_val("en0 ps", 32'(period_start), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick;
         check_val("idle pwm", 32'(pwm), 32'(INV));
         check_val("idle ps", 32'(period_start), 32'd0);
      end

      // Configure while disabled
      en = 1'b0;
      tick;
      check_val("dis pwm", 32'(pwm), 32'(INV));
      check_val("dis ps", 32'(period_start), 32'd0);
      top_wr = 1'b1; top_val = 8'd9;
      set_win(2'd0, 8'd2, 8'd5);
      tick;
      top_wr = 1'b0;
      set_win(2'd1, 8'd0, 8'd10);
      tick;
      set_win(2'd2, 8'd8, 8'd2);
      tick;
      set_win(2'd3, 8'd4, 8'd4);
      tick;
      wr_en = 1'b0;
      tick;
      en = 1'b1;

      // Basic, wrap and empty windows
      repeat (3) run_ctr("basic", TBL_BASE, 0, 9);

      // Shadow commit and write/commit collision
      run_ctr("coll", TBL_BASE, 0, 3);
      set_win(2'd0, 8'd0, 8'd1);
      run_ctr("coll", TBL_BASE, 4, 4);
      wr_en = 1'b0;
      run_ctr("coll", TBL_BASE, 5, 8);
      set_win(2'd0, 8'd0, 8'd9);
      run_ctr("coll", TBL_BASE, 9, 9);
      wr_en = 1'b0;
      run_ctr("next1", TBL_P1, 0, 9);
      run_ctr("next2", TBL_P2, 0, 9);

      // Period change mid-run
      run_ctr("topchg", TBL_P2, 0, 4);
      top_wr = 1'b1; top_val = 8'd3;
      run_ctr("topchg", TBL_P2, 5, 5);
      top_wr = 1'b0;
      run_ctr("topchg", TBL_P2, 6, 9);
      repeat (3) run_ctr("top3", TBL_T3, 0, 3);

      // Back to top 9, then reset at ctr=6 with pending writes
      run_ctr("top3b", TBL_T3, 0, 0);
      top_wr = 1'b1; top_val = 8'd9;
      run_ctr("top3b", TBL_T3, 1, 1);
      top_wr = 1'b0;
      run_ctr("top3b", TBL_T3, 2, 3);
      run_ctr("top9", TBL_P2, 0, 4);
      set_win(2'd3, 8'd0, 8'd5);
      top_wr = 1'b1; top_val = 8'd5;
      run_ctr("top9", TBL_P2, 5, 5);
      wr_en = 1'b0;
      top_wr = 1'b0;
      rst = 1'b1;
      tick;
      check_val("midrst pwm", 32'(pwm), 32'(INV));
      check_val("midrst ps", 32'(period_start), 32'd0);
      rst = 1'b0;
      tick;
      check_val("post pwm0", 32'(pwm), 32'(INV));
      check_val("post ps0", 32'(period_start), 32'd1);
      for (int i = 1; i < 256; i++) begin
         tick;
         check_val($sformatf("post pwm c=%0d", i), 32'(pwm), 32'(INV));
         check_val($sformatf("post ps c=%0d", i), 32'(period_start), 32'd0);
      end
      tick;
      check_val("post pwm256", 32'(pwm), 32'(INV));
      check_val("post ps256", 32'(period_start), 32'd1);

      // top=0: every cycle is a boundary
      en = 1'b0;
      top_wr = 1'b1; top_val = 8'd0;
      set_win(2'd0, 8'd0, 8'd1);
      tick;
      check_val("t0 dis pwm", 32'(pwm), 32'(INV));
      check_val("t0 dis ps", 32'(period_start), 32'd0);
      top_wr = 1'b0;
      wr_en = 1'b0;
      tick;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check_val("t0 pwm", 32'(pwm), 32'(4'b0011));
         check_val("t0 ps", 32'(period_start), 32'd1);
      end
      en = 1'b0;
      tick;
      check_val("t0 off pwm", 32'(pwm), 32'(INV));
      check_val("t0 off ps", 32'(period_start), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
